// File: rtl/k12_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k12_alu_pkg
// Brief    : Shared opcodes, condition codes, flag indices and cc evaluator
//            for the sequential k12 ALU.
// Revision : 1.0 - initial release
// ============================================================================
package k12_alu_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADC   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SBB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_SAR   = 4'd10;
    localparam logic [3:0] OP_ROL   = 4'd11;
    localparam logic [3:0] OP_CMP   = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;

    // Condition codes
    localparam logic [2:0] CC_AL = 3'd0;
    localparam logic [2:0] CC_EQ = 3'd1;
    localparam logic [2:0] CC_NE = 3'd2;
    localparam logic [2:0] CC_CS = 3'd3;
    localparam logic [2:0] CC_CC = 3'd4;
    localparam logic [2:0] CC_MI = 3'd5;
    localparam logic [2:0] CC_VS = 3'd6;
    localparam logic [2:0] CC_LT = 3'd7;

    // Flag bit positions within {N,Z,C,V}
    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    // Evaluate a condition select against a flag vector
    function automatic logic eval_cc(input logic [2:0] sel, input logic [3:0] f);
        logic r;
        case (sel)
            CC_AL:   r = 1'b1;
            CC_EQ:   r = f[F_Z];
            CC_NE:   r = ~f[F_Z];
            CC_CS:   r = f[F_C];
            CC_CC:   r = ~f[F_C];
            CC_MI:   r = f[F_N];
            CC_VS:   r = f[F_V];
            default: r = f[F_N] ^ f[F_V];
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/k12_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : k12_alu_core
// Brief    : Combinational single-cycle datapath: add/sub/logic with flag
//            generation. Shift opcodes produce the amount-zero result
//            (res = a, C kept); multi-bit shifts are iterated by the top.
// Revision : 1.0 - initial release
// ============================================================================
module k12_alu_core
    import k12_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic [3:0]       flags_i,
    output logic [WIDTH-1:0] res_o,
    output logic [3:0]       flags_o
);

    localparam int MSB = WIDTH - 1;

    logic             w_cin_add;
    logic             w_cin_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_v_add;
    logic             w_v_sub;

    assign w_cin_add = (op_i == OP_ADC) & flags_i[F_C];
    assign w_cin_sub = (op_i == OP_SBB) & flags_i[F_C];

    // Extra top bit carries the carry-out on add and the borrow on sub
    assign w_sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, w_cin_add};
    assign w_diff = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, w_cin_sub};

    assign w_v_add = (a_i[MSB] == b_i[MSB]) && (w_sum[MSB]  != a_i[MSB]);
    assign w_v_sub = (a_i[MSB] != b_i[MSB]) && (w_diff[MSB] != a_i[MSB]);

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_nz_src;
    logic             w_nz_en;
    logic             w_c;
    logic             w_v;

    // Result select and per-op flag update rules
    always_comb begin
        w_res   = '0;
        w_nz_en = 1'b1;
        w_c     = flags_i[F_C];
        w_v     = 1'b0;
        case (op_i)
            OP_ADD, OP_ADC: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_v_add;
            end
            OP_SUB, OP_SBB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = w_v_sub;
            end
            OP_CMP: begin
                w_res = a_i;
                w_c   = w_diff[WIDTH];
                w_v   = w_v_sub;
            end
            OP_AND: w_res = a_i & b_i;
            OP_OR:  w_res = a_i | b_i;
            OP_XOR: w_res = a_i ^ b_i;
            OP_NOT: w_res = ~a_i;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL: w_res = a_i;
            OP_PASSB: begin
                w_res = b_i;
                w_v   = flags_i[F_V];
            end
            default: begin
                w_res   = '0;
                w_nz_en = 1'b0;
                w_v     = flags_i[F_V];
            end
        endcase
        // CMP reports N/Z of the difference while passing a through
        w_nz_src = (op_i == OP_CMP) ? w_diff[MSB:0] : w_res;
        res_o    = w_res;
        flags_o  = {w_nz_en ? w_nz_src[MSB]      : flags_i[F_N],
                    w_nz_en ? (w_nz_src == '0)   : flags_i[F_Z],
                    w_c,
                    w_v};
    end

endmodule
`default_nettype wire

// File: rtl/k12_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : k12_alu_seq
// Brief    : Handshaked k12 ALU with persistent NZCV register, one-bit-per-
//            cycle iterative shifter and condition evaluation.
// Revision : 1.0 - initial release
// ============================================================================
module k12_alu_seq
    import k12_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [2:0]       cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             cond
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sh_q;
    logic [3:0]       flags_q;
    logic             cond_q;
    logic             valid_q;
    logic [2:0]       cc_q;
    logic [1:0]       shop_q;
    logic [SHW-1:0]   cnt_q;

    logic             w_accept;
    logic             w_is_shift;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_core_res;
    logic [3:0]       w_core_flags;
    logic [WIDTH-1:0] w_step;
    logic             w_step_c;
    logic [3:0]       w_sh_flags;

    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_amt      = b[SHW-1:0];
    assign w_is_shift = (op[3:2] == 2'b10);

    k12_alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (a),
        .b_i     (b),
        .op_i    (op),
        .flags_i (flags_q),
        .res_o   (w_core_res),
        .flags_o (w_core_flags)
    );

    // One bit of the iterative shift; shop_q is op[1:0] of SHL/SHR/SAR/ROL
    always_comb begin
        w_step   = sh_q;
        w_step_c = 1'b0;
        case (shop_q)
            2'd0: begin w_step = {sh_q[MSB-1:0], 1'b0};     w_step_c = sh_q[MSB]; end
            2'd1: begin w_step = {1'b0, sh_q[MSB:1]};       w_step_c = sh_q[0];   end
            2'd2: begin w_step = {sh_q[MSB], sh_q[MSB:1]};  w_step_c = sh_q[0];   end
            default: begin w_step = {sh_q[MSB-1:0], sh_q[MSB]}; w_step_c = sh_q[MSB]; end
        endcase
        w_sh_flags = {w_step[MSB], (w_step == '0), w_step_c, 1'b0};
    end

    // FSM, shifter state and committed result/flags/cond registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            sh_q    <= '0;
            flags_q <= '0;
            cond_q  <= 1'b0;
            valid_q <= 1'b0;
            cc_q    <= '0;
            shop_q  <= '0;
            cnt_q   <= '0;
        end else if (w_accept) begin
            if (w_is_shift && (w_amt != '0)) begin
                sh_q    <= a;
                cnt_q   <= w_amt;
                shop_q  <= op[1:0];
                cc_q    <= cc;
                valid_q <= 1'b0;
                state_q <= S_SHIFT;
            end else begin
                res_q   <= w_core_res;
                flags_q <= w_core_flags;
                cond_q  <= eval_cc(cc, w_core_flags);
                valid_q <= 1'b1;
                state_q <= S_DONE;
            end
        end else begin
            case (state_q)
                S_SHIFT: begin
                    sh_q  <= w_step;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        res_q   <= w_step;
                        flags_q <= w_sh_flags;
                        cond_q  <= eval_cc(cc_q, w_sh_flags);
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign res       = res_q;
    assign flags     = flags_q;
    assign cond      = cond_q;

endmodule
`default_nettype wire
